// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// IR fields and status flow in; datapath steering and enables flow out.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_op,
        output illegal, state
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_op,
        input  illegal, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multi-cycle RISC-V datapath per instruction.
// Per-state controls are registered from the next state.
module multicycle_control_unit #(
    parameter bit MEM_WAIT     = 1'b1,
    parameter bit SUPPORT_LUI  = 1'b1,
    parameter bit SUPPORT_JALR = 1'b1
) (
    input logic clk,
    input logic reset,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_JALR_T   = 4'd12,
        S_JALR_L   = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       illegal;
        logic       fetch;
        logic       branch;
        logic       pc_update;
        logic       memadr;
    } ctl_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t state_q;
    state_t nxt;
    ctl_t   ctl;
    logic   ready;
    logic   unused;

    assign ready  = MEM_WAIT ? bus.mem_ready : 1'b1;
    assign unused = ^bus.funct3[2:1];

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.result_src = 2'b10;
                c.alu_src_b  = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 3'b010;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.memadr    = 1'b1;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.imm_src   = 3'b011;
                c.pc_update = 1'b1;
            end
            S_LUI: begin
                c.imm_src    = 3'b100;
                c.result_src = 2'b11;
                c.reg_write  = 1'b1;
            end
            S_JALR_T: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            // Link value OldPC+4 is formed here while PC takes ALUOut.
            S_JALR_L: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_ILLEGAL: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = S_FETCH;
        case (state_q)
            S_FETCH: nxt = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:  nxt = S_EXECUTER;
                    OP_ITYPE:  nxt = S_EXECUTEI;
                    OP_BRANCH: nxt = S_BRANCH;
                    OP_JAL:    nxt = S_JAL;
                    OP_LUI:    nxt = SUPPORT_LUI ? S_LUI : S_ILLEGAL;
                    OP_JALR:   nxt = SUPPORT_JALR ? S_JALR_T : S_ILLEGAL;
                    default:   nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   nxt = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  nxt = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: nxt = ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER, S_EXECUTEI, S_JAL: nxt = S_ALUWB;
            S_JALR_T:   nxt = S_JALR_L;
            S_JALR_L:   nxt = S_ALUWB;
            default:    nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctl     <= decode(S_FETCH);
        end else begin
            state_q <= nxt;
            ctl     <= decode(nxt);
        end
    end

    // FETCH enables and the branch decision follow live inputs.
    assign bus.ir_write   = ctl.fetch & ready;
    assign bus.pc_write   = ctl.pc_update | (ctl.fetch & ready)
                          | (ctl.branch & (bus.zero ^ bus.funct3[0]));
    assign bus.imm_src    = ctl.memadr ? {2'b00, bus.opcode[5]}
                                       : ctl.imm_src;
    assign bus.adr_src    = ctl.adr_src;
    assign bus.mem_write  = ctl.mem_write;
    assign bus.reg_write  = ctl.reg_write;
    assign bus.result_src = ctl.result_src;
    assign bus.alu_src_a  = ctl.alu_src_a;
    assign bus.alu_src_b  = ctl.alu_src_b;
    assign bus.alu_op     = ctl.alu_op;
    assign bus.illegal    = ctl.illegal;
    assign bus.state      = state_q;
endmodule
